instruction_decode_pipe: RTL and testbench

Parametrised decode stage that replaces the phase-enabled decoder with an elastic valid/ready pipeline stage. It decodes one RV32I/RV64I instruction per cycle and drives rs1sel/rs2sel combinationally to the register file. It captures the register read data together with the decoded fields into a 2-entry skid buffer. It adds flush, illegal-opcode flagging and RV64 word-op decode. It sits between fetch and the ALU/memory_access stages.

---
 rtl/instruction_decode_pipe_pkg.sv | 59 +++++
 rtl/decode_skid_buffer.sv | 51 +++++
 rtl/instruction_decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_instruction_decode_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pipe_pkg.sv
// Shared decode constants: opcodes, operand/result selectors and the decoded_op field layout.
package instruction_decode_pipe_pkg;

  localparam int unsigned OPLEN = 11;

  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;

  localparam logic USE_RS1_RS1DATA = 1'b0;
  localparam logic USE_RS1_PC      = 1'b1;
  localparam logic USE_RS2_RS2DATA = 1'b0;
  localparam logic USE_RS2_IMM     = 1'b1;

  localparam logic [1:0] USE_RD_ALU    = 2'd0;
  localparam logic [1:0] USE_RD_MEMORY = 2'd1;
  localparam logic [1:0] USE_RD_PC     = 2'd2;
  localparam logic [1:0] USE_RD_COMP   = 2'd3;

  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_JUMP = 3'b010;

  localparam int unsigned DOP_USE_RS1     = 0;
  localparam int unsigned DOP_USE_RS2     = 1;
  localparam int unsigned DOP_USE_RD_LO   = 2;
  localparam int unsigned DOP_FUNCT3_LO   = 4;
  localparam int unsigned DOP_JUMP_EN     = 7;
  localparam int unsigned DOP_DATA_MEM_WE = 8;
  localparam int unsigned DOP_WORD_OP     = 9;
  localparam int unsigned DOP_ILLEGAL     = 10;

  // Field order is MSB first, so each field lands on its DOP_* bit position.
  typedef struct packed {
    logic       illegal;
    logic       word_op;
    logic       data_mem_we;
    logic       jump_en;
    logic [2:0] funct3;
    logic [1:0] use_rd;
    logic       use_rs2;
    logic       use_rs1;
  } decoded_op_t;

  function automatic logic is_word_opcode(input logic [6:0] opcode);
    return (opcode == OPCODE_OP_IMM_32) || (opcode == OPCODE_OP_32);
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Generic two-entry valid/ready buffer: output register plus one skid entry, with flush.
module decode_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             fire;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // Output slot refills from skid first so order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || fire) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        if (accept) skid_data <= in_data;
      end else begin
        out_valid <= accept;
        if (accept) out_data <= in_data;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_decode_pipe.sv
// RV32I/RV64I decode stage: combinational decode and register-file indexing, elastic two-entry output.
module instruction_decode_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OPLEN = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  curr_pc_fd,
  input  logic [XLEN-1:0]  next_pc_fd,
  output logic [4:0]       rs1sel,
  output logic [4:0]       rs2sel,
  input  logic [XLEN-1:0]  rs1data_rd,
  input  logic [XLEN-1:0]  rs2data_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1data_de,
  output logic [XLEN-1:0]  rs2data_de,
  output logic [XLEN-1:0]  curr_pc_de,
  output logic [XLEN-1:0]  next_pc_de,
  output logic [3:0]       funct_alu,
  output logic [4:0]       rdsel_de,
  output logic [OPLEN-1:0] decoded_op_de
);
  import instruction_decode_pipe_pkg::*;

  localparam bit          RV64      = (XLEN == 64);
  localparam int unsigned PAYLOAD_W = 5 * XLEN + 4 + 5 + OPLEN;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm_c;
  logic [4:0]      rdsel_c;
  logic            legal;
  decoded_op_t     op;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1sel = (opcode == OPCODE_LUI) ? 5'd0 : inst[19:15];
  assign rs2sel = inst[24:20];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'd0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    op         = '0;
    op.use_rs1 = USE_RS1_RS1DATA;
    op.use_rs2 = USE_RS2_IMM;
    op.use_rd  = USE_RD_ALU;
    op.funct3  = funct3;
    imm_c      = '0;
    rdsel_c    = inst[11:7];
    legal      = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        legal = 1'b1;
        imm_c = imm_u;
      end
      OPCODE_AUIPC: begin
        legal      = 1'b1;
        imm_c      = imm_u;
        op.use_rs1 = USE_RS1_PC;
      end
      OPCODE_JAL: begin
        legal      = 1'b1;
        imm_c      = imm_j;
        op.use_rs1 = USE_RS1_PC;
        op.use_rd  = USE_RD_PC;
        op.funct3  = FUNCT3_JUMP;
        op.jump_en = 1'b1;
      end
      OPCODE_JALR: begin
        legal      = 1'b1;
        imm_c      = imm_i;
        op.use_rd  = USE_RD_PC;
        op.funct3  = FUNCT3_JUMP;
        op.jump_en = 1'b1;
      end
      OPCODE_BRANCH: begin
        legal      = 1'b1;
        imm_c      = imm_b;
        op.use_rs2 = USE_RS2_RS2DATA;
        op.jump_en = 1'b1;
        rdsel_c    = 5'd0;
      end
      OPCODE_LOAD: begin
        legal     = 1'b1;
        imm_c     = imm_i;
        op.use_rd = USE_RD_MEMORY;
      end
      OPCODE_STORE: begin
        legal          = 1'b1;
        imm_c          = imm_s;
        op.use_rs2     = USE_RS2_RS2DATA;
        op.data_mem_we = 1'b1;
        rdsel_c        = 5'd0;
      end
      OPCODE_OP_IMM: begin
        legal = 1'b1;
        imm_c = imm_i;
        if (funct3 == FUNCT3_SLT || funct3 == FUNCT3_SLTU) op.use_rd = USE_RD_COMP;
      end
      OPCODE_OP: begin
        legal      = 1'b1;
        op.use_rs2 = USE_RS2_RS2DATA;
        if (funct3 == FUNCT3_SLT || funct3 == FUNCT3_SLTU) op.use_rd = USE_RD_COMP;
      end
      OPCODE_MISC_MEM: legal = 1'b1;
      OPCODE_SYSTEM: begin
        legal = 1'b1;
        if (funct3[2]) op.use_rs1 = USE_RS1_PC;
      end
      OPCODE_OP_IMM_32: begin
        legal      = RV64;
        imm_c      = imm_i;
        op.word_op = RV64;
      end
      OPCODE_OP_32: begin
        legal      = RV64;
        op.use_rs2 = USE_RS2_RS2DATA;
        op.word_op = RV64;
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions must never write state or redirect fetch.
    op.illegal = !legal || (inst[1:0] != 2'b11);
    if (op.illegal) begin
      op.jump_en     = 1'b0;
      op.data_mem_we = 1'b0;
      op.word_op     = 1'b0;
      rdsel_c        = 5'd0;
    end
  end

  assign in_payload = {imm_c, rs1data_rd, rs2data_rd, curr_pc_fd, next_pc_fd,
                       inst[30], funct3, rdsel_c, OPLEN'(op)};

  decode_skid_buffer #(.WIDTH(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de,
          funct_alu, rdsel_de, decoded_op_de} = out_payload;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Bench for instruction_decode_pipe: XLEN=32 and XLEN=64 instances against a queue-based reference model.
module tb_instruction_decode_pipe;
  import instruction_decode_pipe_pkg::*;

  localparam int unsigned VW = 5 * 64 + 4 + 5 + 11;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] cpc = '0, npc = '0, r1d = '0, r2d = '0;

  logic in_ready32, out_valid32, in_ready64, out_valid64;
  logic [4:0] rs1sel32, rs2sel32, rd32, rs1sel64, rs2sel64, rd64;
  logic [31:0] imm32, rs1de32, rs2de32, cpcde32, npcde32;
  logic [63:0] imm64, rs1de64, rs2de64, cpcde64, npcde64;
  logic [3:0] fa32, fa64;
  logic [10:0] op32, op64;

  always #5 clk = ~clk;

  instruction_decode_pipe #(.XLEN(32), .OPLEN(11)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .curr_pc_fd(cpc[31:0]), .next_pc_fd(npc[31:0]),
    .rs1sel(rs1sel32), .rs2sel(rs2sel32), .rs1data_rd(r1d[31:0]), .rs2data_rd(r2d[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .rs1data_de(rs1de32), .rs2data_de(rs2de32), .curr_pc_de(cpcde32), .next_pc_de(npcde32),
    .funct_alu(fa32), .rdsel_de(rd32), .decoded_op_de(op32));

  instruction_decode_pipe #(.XLEN(64), .OPLEN(11)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .curr_pc_fd(cpc), .next_pc_fd(npc),
    .rs1sel(rs1sel64), .rs2sel(rs2sel64), .rs1data_rd(r1d), .rs2data_rd(r2d),
    .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .rs1data_de(rs1de64), .rs2data_de(rs2de64), .curr_pc_de(cpcde64), .next_pc_de(npcde64),
    .funct_alu(fa64), .rdsel_de(rd64), .decoded_op_de(op64));

  logic [VW-1:0] obs32, obs64;
  assign obs32 = {64'(imm32), 64'(rs1de32), 64'(rs2de32), 64'(cpcde32), 64'(npcde32), fa32, rd32, op32};
  assign obs64 = {imm64, rs1de64, rs2de64, cpcde64, npcde64, fa64, rd64, op64};

  typedef struct {
    logic [31:0] inst;
    logic [63:0] cpc, npc, r1, r2;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] s;
    s = 64'd1 << (bits - 1);
    return (v ^ s) - s;
  endfunction

  // Expected outputs straight from the instruction-set rules; 32-bit results zero-extended.
  function automatic logic [VW-1:0] expect_out(input ent_t e, input bit x64);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [63:0] im, m;
    logic [4:0] rd;
    logic [10:0] op;
    bit word, legal;
    opc = e.inst[6:0];
    f3 = e.inst[14:12];
    m = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    word = (opc == OPCODE_OP_IMM_32) || (opc == OPCODE_OP_32);
    legal = (e.inst[1:0] == 2'b11) &&
            ((opc inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
                          OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
                          OPCODE_MISC_MEM, OPCODE_SYSTEM}) || (word && x64));
    im = '0;
    if (opc inside {OPCODE_LUI, OPCODE_AUIPC}) im = sext({32'd0, e.inst[31:12], 12'd0}, 32);
    else if (opc == OPCODE_JAL)
      im = sext({43'd0, e.inst[31], e.inst[19:12], e.inst[20], e.inst[30:21], 1'b0}, 21);
    else if (opc inside {OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_OP_IMM_32})
      im = sext({52'd0, e.inst[31:20]}, 12);
    else if (opc == OPCODE_BRANCH)
      im = sext({51'd0, e.inst[31], e.inst[7], e.inst[30:25], e.inst[11:8], 1'b0}, 13);
    else if (opc == OPCODE_STORE) im = sext({52'd0, e.inst[31:25], e.inst[11:7]}, 12);
    op = '0;
    op[0] = (opc inside {OPCODE_AUIPC, OPCODE_JAL}) || (opc == OPCODE_SYSTEM && f3[2]);
    op[1] = !(opc inside {OPCODE_BRANCH, OPCODE_STORE, OPCODE_OP, OPCODE_OP_32});
    if (opc inside {OPCODE_JAL, OPCODE_JALR}) op[3:2] = USE_RD_PC;
    else if (opc == OPCODE_LOAD) op[3:2] = USE_RD_MEMORY;
    else if ((opc inside {OPCODE_OP_IMM, OPCODE_OP}) && (f3 == 3'd2 || f3 == 3'd3)) op[3:2] = USE_RD_COMP;
    else op[3:2] = USE_RD_ALU;
    op[6:4] = (opc inside {OPCODE_JAL, OPCODE_JALR}) ? FUNCT3_JUMP : f3;
    op[7] = legal && (opc inside {OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH});
    op[8] = legal && (opc == OPCODE_STORE);
    op[9] = x64 && word;
    op[10] = !legal;
    rd = (!legal || (opc inside {OPCODE_STORE, OPCODE_BRANCH})) ? 5'd0 : e.inst[11:7];
    return {im & m, e.r1 & m, e.r2 & m, e.cpc & m, e.npc & m, e.inst[30], f3, rd, op};
  endfunction

  // One clock: the model accepts/fires from pre-edge inputs, then outputs are sampled 1 time unit later.
  task automatic tick();
    bit acc, fir;
    acc = in_valid && (q.size() < 2);
    fir = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back('{inst, cpc, npc, r1d, r2d});
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] i);
    inst = i;
    in_valid = 1'b1;
    cpc = {$urandom, $urandom};
    npc = cpc + 64'd4;
    r1d = {$urandom, $urandom};
    r2d = {$urandom, $urandom};
  endtask

  logic [6:0] opc_tbl [13] = '{OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
                               OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
                               OPCODE_MISC_MEM, OPCODE_SYSTEM, OPCODE_OP_IMM_32, OPCODE_OP_32};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = opc_tbl[k];
    else if (k == 13) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(32'h0050_0093);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid32, out_valid64} !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b want 00", {out_valid32, out_valid64}); end
    checks++; if ({in_ready32, in_ready64} !== 2'b11) begin errors++; $display("FAIL reset_in_ready got %b want 11", {in_ready32, in_ready64}); end
    checks++; if (obs32 !== '0 || obs64 !== '0) begin errors++; $display("FAIL reset_payload got %0h / %0h want 0", obs32, obs64); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(32'h0050_0093);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid32); end
    checks++; if (imm32 !== 32'h5 || rd32 !== 5'd1) begin errors++; $display("FAIL addi_imm_rd got %0h %0d want 5 1", imm32, rd32); end
    checks++; if (op32[1] !== USE_RS2_IMM || op32[3:2] !== USE_RD_ALU || fa32 !== 4'b0000 || op32[10] !== 1'b0)
      begin errors++; $display("FAIL addi_fields got op=%0h fa=%0h want rs2=imm rd=alu fa=0 legal", op32, fa32); end
    checks++; if (obs32 !== expect_out(q[0], 1'b0)) begin errors++; $display("FAIL addi_model got %0h want %0h", obs32, expect_out(q[0], 1'b0)); end
    tick();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", out_valid32); end
  endtask

  task automatic test_lui64();
    out_ready = 1'b1;
    drive(32'h8000_02B7);
    #1;
    checks++; if (rs1sel64 !== 5'd0 || rs1sel32 !== 5'd0) begin errors++; $display("FAIL lui_rs1sel got %0d %0d want 0", rs1sel64, rs1sel32); end
    tick();
    in_valid = 1'b0;
    checks++; if (imm64 !== 64'hFFFF_FFFF_8000_0000 || rd64 !== 5'd5) begin errors++; $display("FAIL lui_imm_rd got %0h %0d want ffffffff80000000 5", imm64, rd64); end
    checks++; if (obs64 !== expect_out(q[0], 1'b1)) begin errors++; $display("FAIL lui_model got %0h want %0h", obs64, expect_out(q[0], 1'b1)); end
    tick();
  endtask

  task automatic test_word_op();
    out_ready = 1'b1;
    drive(32'h0010_009B);
    tick();
    in_valid = 1'b0;
    checks++; if (op64[9] !== 1'b1 || op64[10] !== 1'b0 || imm64 !== 64'd1) begin errors++; $display("FAIL addiw64 got word=%b ill=%b imm=%0h want 1 0 1", op64[9], op64[10], imm64); end
    checks++; if (op32[10] !== 1'b1 || rd32 !== 5'd0 || op32[9] !== 1'b0) begin errors++; $display("FAIL addiw32 got ill=%b rd=%0d word=%b want 1 0 0", op32[10], rd32, op32[9]); end
    checks++; if (obs32 !== expect_out(q[0], 1'b0) || obs64 !== expect_out(q[0], 1'b1)) begin errors++; $display("FAIL addiw_model got %0h / %0h", obs32, obs64); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] hold;
    int got[$];
    out_ready = 1'b0;
    drive(32'h0010_0093); tick();
    drive(32'h0020_0113); tick();
    drive(32'h0030_0193);
    checks++; if ({in_ready32, in_ready64} !== 2'b00) begin errors++; $display("FAIL bp_in_ready got %b want 00", {in_ready32, in_ready64}); end
    hold = obs64;
    tick(); tick();
    checks++; if (obs64 !== hold || obs64 !== expect_out(q[0], 1'b1)) begin errors++; $display("FAIL bp_stall_hold got %0h want %0h", obs64, hold); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bit take;
      take = in_valid && in_ready64;
      if (out_valid64) got.push_back(int'(rd64));
      tick();
      if (take) in_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] != k + 1) begin errors++; $display("FAIL bp_order[%0d] got %0d want %0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h0010_0093); tick();
    drive(32'h0020_0113); tick();
    drive(32'h0040_0213);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid32, out_valid64} !== 2'b00 || {in_ready32, in_ready64} !== 2'b11)
      begin errors++; $display("FAIL flush_state got v=%b r=%b want 00 11", {out_valid32, out_valid64}, {in_ready32, in_ready64}); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_valid64 !== 1'b0 || out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_leak got %b %b rd=%0d want 0", out_valid32, out_valid64, rd64); end
    end
  endtask

  task automatic test_illegal_and_reset();
    out_ready = 1'b1;
    drive(32'h0000_007F);
    tick();
    in_valid = 1'b0;
    checks++; if (op64[10] !== 1'b1 || op64[7] !== 1'b0 || op64[8] !== 1'b0 || rd64 !== 5'd0)
      begin errors++; $display("FAIL illegal_fields got op=%0h rd=%0d want ill=1 je=0 we=0 rd=0", op64, rd64); end
    checks++; if (obs32 !== expect_out(q[0], 1'b0)) begin errors++; $display("FAIL illegal_model got %0h want %0h", obs32, expect_out(q[0], 1'b0)); end
    out_ready = 1'b0;
    drive(32'h0010_0093); tick();
    drive(32'h0020_0113);
    checks++; if (out_valid64 !== 1'b1 || in_ready64 !== 1'b0) begin errors++; $display("FAIL full_before_rst got v=%b r=%b want 1 0", out_valid64, in_ready64); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid32, out_valid64} !== 2'b00 || obs32 !== '0 || obs64 !== '0 || {in_ready32, in_ready64} !== 2'b11)
      begin errors++; $display("FAIL mid_rst got v=%b %0h / %0h want 0 and zero payload", {out_valid32, out_valid64}, obs32, obs64); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      checks++; if (out_valid32 !== (q.size() > 0) || out_valid64 !== (q.size() > 0) ||
                    in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2))
        begin errors++; $display("FAIL rnd_hs cyc=%0d got v=%b%b r=%b%b want q=%0d", c, out_valid32, out_valid64, in_ready32, in_ready64, q.size()); end
      if (q.size() > 0) begin
        checks++; if (obs32 !== expect_out(q[0], 1'b0)) begin errors++; $display("FAIL rnd_out32 cyc=%0d inst=%h got %0h want %0h", c, q[0].inst, obs32, expect_out(q[0], 1'b0)); end
        checks++; if (obs64 !== expect_out(q[0], 1'b1)) begin errors++; $display("FAIL rnd_out64 cyc=%0d inst=%h got %0h want %0h", c, q[0].inst, obs64, expect_out(q[0], 1'b1)); end
      end
      drive(rand_inst());
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      #1;
      checks++; if (rs1sel64 !== ((inst[6:0] == OPCODE_LUI) ? 5'd0 : inst[19:15]) || rs2sel32 !== inst[24:20])
        begin errors++; $display("FAIL rnd_sel inst=%h got %0d %0d", inst, rs1sel64, rs2sel32); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui64();
    test_word_op();
    test_back_to_back();
    test_flush();
    test_illegal_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
